// File: rtl/reg_file_rsp.sv
// Two-read/one-write register file with a per-register busy scoreboard.
// Reads of a reserved register wait for the matching writeback and forward its data.
module reg_file_rsp #(
    parameter int unsigned WIDTH        = 32,
    parameter int unsigned REG_ADDR_LEN = 5
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic [REG_ADDR_LEN-1:0]      Rd1_addr,
    input  logic                         Rd1_en,
    output logic [WIDTH-1:0]             Rd1_data,
    output logic                         Rd1_st,
    input  logic [REG_ADDR_LEN-1:0]      Rd2_addr,
    input  logic                         Rd2_en,
    output logic [WIDTH-1:0]             Rd2_data,
    output logic                         Rd2_st,
    input  logic                         Rsv_en,
    input  logic [REG_ADDR_LEN-1:0]      Rsv_addr,
    input  logic                         Wr_en,
    input  logic [REG_ADDR_LEN-1:0]      Wr_addr,
    input  logic [WIDTH-1:0]             Wr_data,
    input  logic                         IsFlush,
    output logic [(2**REG_ADDR_LEN)-1:0] Busy_vec
);

    localparam int unsigned NUM_REGS = 2 ** REG_ADDR_LEN;

    localparam logic StIdle = 1'b0;
    localparam logic StWait = 1'b1;

    logic [WIDTH-1:0]        mem_q [NUM_REGS];
    logic [NUM_REGS-1:0]     busy_q, busy_d;

    logic [1:0]              state_q, state_d;
    logic [1:0]              st_q, st_d;
    logic [REG_ADDR_LEN-1:0] addr_q [2];
    logic [REG_ADDR_LEN-1:0] addr_d [2];
    logic [WIDTH-1:0]        data_q [2];
    logic [WIDTH-1:0]        data_d [2];

    logic [1:0]              req_en;
    logic [REG_ADDR_LEN-1:0] req_addr [2];

    always_comb begin
        req_en      = {Rd2_en, Rd1_en};
        req_addr[0] = Rd1_addr;
        req_addr[1] = Rd2_addr;
    end

    // Write clears first, then a reservation sets, so a same-cycle reserve wins.
    always_comb begin
        busy_d = busy_q;
        if (Wr_en) begin
            busy_d[Wr_addr] = 1'b0;
        end
        if (Rsv_en) begin
            busy_d[Rsv_addr] = 1'b1;
        end
        busy_d[0] = 1'b0;
    end

    // Reads use busy_q, i.e. the state before this cycle's reservation.
    always_comb begin
        for (int p = 0; p < 2; p++) begin
            state_d[p] = state_q[p];
            addr_d[p]  = addr_q[p];
            data_d[p]  = data_q[p];
            st_d[p]    = 1'b0;
            if (IsFlush) begin
                state_d[p] = StIdle;
            end else if (req_en[p]) begin
                state_d[p] = StIdle;
                addr_d[p]  = req_addr[p];
                if (req_addr[p] == '0) begin
                    st_d[p]   = 1'b1;
                    data_d[p] = '0;
                end else if (Wr_en && (Wr_addr == req_addr[p])) begin
                    st_d[p]   = 1'b1;
                    data_d[p] = Wr_data;
                end else if (busy_q[req_addr[p]]) begin
                    state_d[p] = StWait;
                end else begin
                    st_d[p]   = 1'b1;
                    data_d[p] = mem_q[req_addr[p]];
                end
            end else if ((state_q[p] == StWait) && Wr_en && (Wr_addr == addr_q[p])) begin
                state_d[p] = StIdle;
                st_d[p]    = 1'b1;
                data_d[p]  = Wr_data;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < NUM_REGS; i++) begin
                mem_q[i] <= '0;
            end
            busy_q  <= '0;
            state_q <= {StIdle, StIdle};
            st_q    <= '0;
            for (int p = 0; p < 2; p++) begin
                addr_q[p] <= '0;
                data_q[p] <= '0;
            end
        end else begin
            if (Wr_en && (Wr_addr != '0)) begin
                mem_q[Wr_addr] <= Wr_data;
            end
            busy_q  <= busy_d;
            state_q <= state_d;
            st_q    <= st_d;
            for (int p = 0; p < 2; p++) begin
                addr_q[p] <= addr_d[p];
                data_q[p] <= data_d[p];
            end
        end
    end

    assign Rd1_data = data_q[0];
    assign Rd2_data = data_q[1];
    assign Rd1_st   = st_q[0];
    assign Rd2_st   = st_q[1];
    assign Busy_vec = busy_q;

endmodule

// File: tb/tb_reg_file_rsp.sv
// Scoreboard bench for reg_file_rsp: stimulus queues expected (cycle, data) per read port,
// a negedge monitor pops and compares on every strobe.
module tb_reg_file_rsp;

    logic        clk;
    logic        rst;
    logic [4:0]  Rd1_addr, Rd2_addr, Rsv_addr, Wr_addr;
    logic        Rd1_en, Rd2_en, Rsv_en, Wr_en, IsFlush;
    logic [31:0] Rd1_data, Rd2_data, Wr_data;
    logic        Rd1_st, Rd2_st;
    logic [31:0] Busy_vec;

    reg_file_rsp #(
        .WIDTH        (32),
        .REG_ADDR_LEN (5)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .Rd1_addr (Rd1_addr),
        .Rd1_en   (Rd1_en),
        .Rd1_data (Rd1_data),
        .Rd1_st   (Rd1_st),
        .Rd2_addr (Rd2_addr),
        .Rd2_en   (Rd2_en),
        .Rd2_data (Rd2_data),
        .Rd2_st   (Rd2_st),
        .Rsv_en   (Rsv_en),
        .Rsv_addr (Rsv_addr),
        .Wr_en    (Wr_en),
        .Wr_addr  (Wr_addr),
        .Wr_data  (Wr_data),
        .IsFlush  (IsFlush),
        .Busy_vec (Busy_vec)
    );

    typedef struct packed {
        int unsigned cyc;
        logic [31:0] data;
    } exp_t;

    exp_t q1[$];
    exp_t q2[$];
    int   checks = 0;
    int   errors = 0;
    int unsigned cyc = 0;

    initial clk = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic mon(input int p, input logic [31:0] d);
        exp_t e;
        checks++;
        if ((p == 1 && q1.size() == 0) || (p == 2 && q2.size() == 0)) begin
            errors++;
            $display("FAIL rd%0d_strobe: unexpected strobe at cycle %0d data %h, required none",
                     p, cyc, d);
        end else begin
            e = (p == 1) ? q1.pop_front() : q2.pop_front();
            if (e.cyc != cyc || e.data !== d) begin
                errors++;
                $display("FAIL rd%0d_resp: got cycle %0d data %h, required cycle %0d data %h",
                         p, cyc, d, e.cyc, e.data);
            end
        end
    endtask

    always @(negedge clk) begin
        if (Rd1_st === 1'b1) mon(1, Rd1_data);
        if (Rd2_st === 1'b1) mon(2, Rd2_data);
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h, required %h", name, act, exp);
        end
    endtask

    task automatic push1(input logic [31:0] d);
        q1.push_back('{cyc + 1, d});
    endtask

    task automatic push2(input logic [31:0] d);
        q2.push_back('{cyc + 1, d});
    endtask

    task automatic next();
        @(posedge clk);
        #1;
        rst = 1'b0; Rd1_en = 1'b0; Rd2_en = 1'b0; Rsv_en = 1'b0; Wr_en = 1'b0; IsFlush = 1'b0;
    endtask

    task automatic wr(input logic [4:0] a, input logic [31:0] d);
        Wr_en = 1'b1; Wr_addr = a; Wr_data = d;
    endtask

    task automatic rsv(input logic [4:0] a);
        Rsv_en = 1'b1; Rsv_addr = a;
    endtask

    task automatic rd1(input logic [4:0] a);
        Rd1_en = 1'b1; Rd1_addr = a;
    endtask

    task automatic rd2(input logic [4:0] a);
        Rd2_en = 1'b1; Rd2_addr = a;
    endtask

    initial begin
        Rd1_addr = '0; Rd2_addr = '0; Rsv_addr = '0; Wr_addr = '0; Wr_data = '0;
        Rd1_en = 0; Rd2_en = 0; Rsv_en = 0; Wr_en = 0; IsFlush = 0;
        rst = 1'b1;
        next();
        check("reset_busy", Busy_vec, 32'h0);
        check("reset_rd1_data", Rd1_data, 32'h0);
        check("reset_rd2_data", Rd2_data, 32'h0);
        check("reset_strobes", {30'h0, Rd2_st, Rd1_st}, 32'h0);

        // Plain write then read, then data held.
        wr(5, 32'hDEADBEEF); next(); next();
        rd1(5); push1(32'hDEADBEEF); next(); next();
        check("rd1_hold_data", Rd1_data, 32'hDEADBEEF);
        check("rd1_st_low", {31'h0, Rd1_st}, 32'h0);

        // Read of a reserved register waits for writeback.
        rsv(3); next();
        check("busy3_set", {31'h0, Busy_vec[3]}, 32'h1);
        next();
        rd2(3); next();
        repeat (3) next();
        check("busy3_held", {31'h0, Busy_vec[3]}, 32'h1);
        wr(3, 32'h1234); push2(32'h1234); next();
        check("busy3_clear", {31'h0, Busy_vec[3]}, 32'h0);
        next();

        // Read and reserve in the same cycle sees the old busy state.
        wr(1, 32'h11); next();
        rd1(1); rsv(1); push1(32'h11); next();
        check("busy1_set", {31'h0, Busy_vec[1]}, 32'h1);
        wr(1, 32'h22); next();
        check("busy1_clear", {31'h0, Busy_vec[1]}, 32'h0);
        // Reserve and write together: reservation wins.
        wr(2, 32'h5); rsv(2); next();
        check("busy2_rsv_wins", {31'h0, Busy_vec[2]}, 32'h1);
        wr(2, 32'h6); next();

        // Write-through forwarding and register 0.
        wr(7, 32'hAA); rd1(7); rd2(0); push1(32'hAA); push2(32'h0); next();
        wr(0, 32'h55); rsv(0); next();
        check("busy0_never", {31'h0, Busy_vec[0]}, 32'h0);
        rd1(0); push1(32'h0); next();
        // Back-to-back reads.
        rd1(5); push1(32'hDEADBEEF); next();
        rd1(7); push1(32'hAA); next();
        next();

        // Flush cancels a waiting read and drops a same-cycle request.
        rsv(9); next();
        rd1(9); next();
        IsFlush = 1'b1; rd2(5); next();
        next();
        check("busy9_after_flush", {31'h0, Busy_vec[9]}, 32'h1);
        wr(9, 32'h99); next();
        check("busy9_clear", {31'h0, Busy_vec[9]}, 32'h0);
        rd1(9); push1(32'h99); next();
        next();

        // A new request replaces a pending wait.
        rsv(10); next();
        rd1(10); next();
        rd1(5); push1(32'hDEADBEEF); next();
        wr(10, 32'h1010); next();
        next();

        // Reset discards a pending wait.
        rsv(4); wr(4, 32'h4444); next();
        rd1(4); next();
        rst = 1'b1; next();
        check("rst_busy", Busy_vec, 32'h0);
        check("rst_rd1_data", Rd1_data, 32'h0);
        check("rst_rd2_data", Rd2_data, 32'h0);
        check("rst_strobes", {30'h0, Rd2_st, Rd1_st}, 32'h0);
        rd1(4); push1(32'h0); next();
        wr(4, 32'h44); next();
        next();

        for (int i = 0; i < 20 && (q1.size() != 0 || q2.size() != 0); i++) next();
        checks++;
        if (q1.size() != 0 || q2.size() != 0) begin
            errors++;
            $display("FAIL pending_responses: got %0d/%0d outstanding, required 0/0",
                     q1.size(), q2.size());
        end

        $display("End of test - %0d assertions evaluated, %0d failures", checks, errors);
        $finish;
    end

endmodule
